// File: rtl/hdma_pkg.sv
// Shared types and constants for the HDMA block-transfer engine.
package hdma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_MOVE,
        ST_BLK_DONE,
        ST_HB_WAIT
    } state_t;

    typedef enum logic [1:0] {
        PH_RD_ADDR,
        PH_RD_DATA,
        PH_WR_DATA,
        PH_WR_WAIT
    } phase_t;

    localparam logic [2:0] SEL_SRC_HI = 3'd0;
    localparam logic [2:0] SEL_SRC_LO = 3'd1;
    localparam logic [2:0] SEL_DST_HI = 3'd2;
    localparam logic [2:0] SEL_DST_LO = 3'd3;
    localparam logic [2:0] SEL_CTRL   = 3'd4;

    localparam logic [1:0] CT_ALIGN = 2'b11;

    function automatic logic [7:0] status_byte(input logic active, input logic [6:0] rem);
        return {~active, rem};
    endfunction

endpackage

// File: rtl/hdma_mover.sv
// Four-phase byte mover: copies one block from the source counter to the
// windowed destination counter, one byte every four clocks.
module hdma_mover #(
    parameter int          BLOCK_BYTES = 16,
    parameter logic [15:0] DST_BASE    = 16'h8000,
    parameter int          DST_WIN_W   = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        src_ld,
    input  logic        dst_ld,
    input  logic [15:0] src_in,
    input  logic [15:0] dst_in,
    output logic        block_done,
    output logic        dma_rd,
    output logic        dma_wr,
    output logic [15:0] dma_a,
    input  logic [7:0]  dma_din,
    output logic [7:0]  dma_dout
);
    import hdma_pkg::*;

    localparam int          OFS_W    = $clog2(BLOCK_BYTES);
    localparam logic [15:0] OFS_MASK = 16'(BLOCK_BYTES - 1);
    localparam logic [15:0] WIN_MASK = 16'((1 << DST_WIN_W) - 1);

    phase_t           phase_reg;
    logic             running_reg;
    logic [OFS_W-1:0] byte_cnt_reg;
    logic [15:0]      src_cnt_reg;
    logic [15:0]      dst_cnt_reg;
    logic [7:0]       dout_reg;
    logic [15:0]      dst_step;
    logic             last_byte;

    assign last_byte  = &byte_cnt_reg;
    // Destination increments stay inside the window; the base bits never change.
    assign dst_step   = DST_BASE | ((dst_cnt_reg + 16'd1) & WIN_MASK);
    assign block_done = running_reg && (phase_reg == PH_WR_WAIT) && last_byte;

    assign dma_rd   = running_reg && ((phase_reg == PH_RD_ADDR) || (phase_reg == PH_RD_DATA));
    assign dma_wr   = running_reg && (phase_reg == PH_WR_DATA);
    assign dma_dout = dout_reg;

    always_comb begin
        dma_a = 16'h0000;
        if (running_reg) begin
            dma_a = ((phase_reg == PH_RD_ADDR) || (phase_reg == PH_RD_DATA)) ? src_cnt_reg
                                                                              : dst_cnt_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg    <= PH_RD_ADDR;
            running_reg  <= 1'b0;
            byte_cnt_reg <= '0;
            src_cnt_reg  <= 16'h0000;
            dst_cnt_reg  <= 16'h0000;
            dout_reg     <= 8'h00;
        end else begin
            if (src_ld) begin
                src_cnt_reg <= src_in & ~OFS_MASK;
            end
            if (dst_ld) begin
                dst_cnt_reg <= DST_BASE | (dst_in & WIN_MASK & ~OFS_MASK);
            end
            if (start) begin
                running_reg  <= 1'b1;
                phase_reg    <= PH_RD_ADDR;
                byte_cnt_reg <= '0;
            end else if (running_reg) begin
                case (phase_reg)
                    PH_RD_ADDR: phase_reg <= PH_RD_DATA;
                    PH_RD_DATA: begin
                        phase_reg <= PH_WR_DATA;
                        dout_reg  <= dma_din;
                    end
                    PH_WR_DATA: phase_reg <= PH_WR_WAIT;
                    default: begin
                        src_cnt_reg  <= src_cnt_reg + 16'd1;
                        dst_cnt_reg  <= dst_step;
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        phase_reg    <= PH_RD_ADDR;
                        if (last_byte) begin
                            running_reg <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/hdma.sv
// HDMA engine top: register file, general/HBlank sequencing, cancel/restart
// handling and HBlank edge capture around the byte mover.
module hdma #(
    parameter int          BLOCK_BYTES = 16,
    parameter int          LEN_W       = 7,
    parameter logic [15:0] DST_BASE    = 16'h8000,
    parameter int          DST_WIN_W   = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ct,
    input  logic        hblank,
    input  logic        lcd_en,
    input  logic [2:0]  mmio_sel,
    input  logic        mmio_wr,
    input  logic [7:0]  mmio_din,
    output logic [7:0]  mmio_dout,
    output logic        dma_rd,
    output logic        dma_wr,
    output logic [15:0] dma_a,
    input  logic [7:0]  dma_din,
    output logic [7:0]  dma_dout,
    output logic        dma_occupy_bus,
    output logic        busy
);
    import hdma_pkg::*;

    state_t           state_reg, state_next;
    logic [15:0]      src_sh_reg, dst_sh_reg;
    logic             mode_reg, mode_next;
    logic [LEN_W-1:0] rem_reg, rem_next;
    logic [LEN_W-1:0] restart_len_reg, restart_len_next;
    logic             cancel_reg, cancel_next;
    logic             restart_reg, restart_next;
    logic             hb_prev_reg;
    logic             hb_pend_reg, hb_pend_next;

    logic             ctrl_wr, ctrl_hb, hb_rise;
    logic [LEN_W-1:0] ctrl_len, rem_dec, reload_len;
    logic             start, load, reload, block_done;

    assign ctrl_wr  = mmio_wr && (mmio_sel == SEL_CTRL);
    assign ctrl_hb  = mmio_din[7];
    assign ctrl_len = mmio_din[LEN_W-1:0];
    assign hb_rise  = hblank && !hb_prev_reg;
    // A block that ends on remaining==0 completes the transfer: back to all-ones.
    assign rem_dec  = (rem_reg == '0) ? '1 : rem_reg - LEN_W'(1);

    assign busy           = (state_reg != ST_IDLE);
    assign dma_occupy_bus = (state_reg == ST_ALIGN) || (state_reg == ST_MOVE) ||
                            (state_reg == ST_BLK_DONE);
    assign mmio_dout      = (mmio_sel == SEL_CTRL) ? status_byte(busy, 7'(rem_reg)) : 8'hFF;

    always_comb begin
        state_next       = state_reg;
        mode_next        = mode_reg;
        rem_next         = rem_reg;
        restart_len_next = restart_len_reg;
        cancel_next      = cancel_reg;
        restart_next     = restart_reg;
        hb_pend_next     = hb_pend_reg;
        start            = 1'b0;
        load             = 1'b0;
        reload           = 1'b0;
        reload_len       = ctrl_len;

        if (hb_rise && mode_reg && ((state_reg == ST_ALIGN) || (state_reg == ST_MOVE))) begin
            hb_pend_next = 1'b1;
        end

        // A CTRL write during an HBlank block is deferred to the block boundary.
        if (ctrl_wr && mode_reg && ((state_reg == ST_ALIGN) || (state_reg == ST_MOVE))) begin
            restart_next     = ctrl_hb;
            cancel_next      = !ctrl_hb;
            restart_len_next = ctrl_len;
        end

        case (state_reg)
            ST_IDLE: begin
                if (ctrl_wr) begin
                    mode_next    = ctrl_hb;
                    rem_next     = ctrl_len;
                    load         = 1'b1;
                    hb_pend_next = 1'b0;
                    state_next   = (ctrl_hb && lcd_en) ? ST_HB_WAIT : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (ct == CT_ALIGN) begin
                    start      = 1'b1;
                    state_next = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (block_done) begin
                    state_next = ST_BLK_DONE;
                end
            end
            ST_BLK_DONE: begin
                if (ctrl_wr && mode_reg) begin
                    if (ctrl_hb) begin
                        reload = 1'b1;
                    end else begin
                        rem_next   = rem_dec;
                        state_next = ST_IDLE;
                    end
                end else if (restart_reg) begin
                    reload     = 1'b1;
                    reload_len = restart_len_reg;
                end else if (rem_reg == '0) begin
                    rem_next   = '1;
                    state_next = ST_IDLE;
                end else if (cancel_reg) begin
                    rem_next   = rem_dec;
                    state_next = ST_IDLE;
                end else begin
                    rem_next = rem_dec;
                    if (!mode_reg || hb_pend_reg || hb_rise || !lcd_en) begin
                        state_next = ST_ALIGN;
                    end else begin
                        state_next = ST_HB_WAIT;
                    end
                    hb_pend_next = 1'b0;
                end
            end
            ST_HB_WAIT: begin
                if (ctrl_wr) begin
                    if (ctrl_hb) begin
                        reload = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (hb_rise || !lcd_en) begin
                    state_next = ST_ALIGN;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (reload) begin
            rem_next     = reload_len;
            load         = 1'b1;
            hb_pend_next = 1'b0;
            cancel_next  = 1'b0;
            restart_next = 1'b0;
            state_next   = lcd_en ? ST_HB_WAIT : ST_ALIGN;
        end

        if (state_next == ST_IDLE) begin
            cancel_next  = 1'b0;
            restart_next = 1'b0;
            hb_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            src_sh_reg      <= 16'h0000;
            dst_sh_reg      <= 16'h0000;
            mode_reg        <= 1'b0;
            rem_reg         <= '1;
            restart_len_reg <= '0;
            cancel_reg      <= 1'b0;
            restart_reg     <= 1'b0;
            hb_prev_reg     <= 1'b0;
            hb_pend_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mode_reg        <= mode_next;
            rem_reg         <= rem_next;
            restart_len_reg <= restart_len_next;
            cancel_reg      <= cancel_next;
            restart_reg     <= restart_next;
            hb_prev_reg     <= hblank;
            hb_pend_reg     <= hb_pend_next;
            // Shadow address registers; the mover only sees them on a CTRL load.
            if (mmio_wr) begin
                case (mmio_sel)
                    SEL_SRC_HI: src_sh_reg[15:8] <= mmio_din;
                    SEL_SRC_LO: src_sh_reg[7:0]  <= mmio_din;
                    SEL_DST_HI: dst_sh_reg[15:8] <= mmio_din;
                    SEL_DST_LO: dst_sh_reg[7:0]  <= mmio_din;
                    default: ;
                endcase
            end
        end
    end

    hdma_mover #(
        .BLOCK_BYTES(BLOCK_BYTES),
        .DST_BASE   (DST_BASE),
        .DST_WIN_W  (DST_WIN_W)
    ) u_mover (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_ld    (load),
        .dst_ld    (load),
        .src_in    (src_sh_reg),
        .dst_in    (dst_sh_reg),
        .block_done(block_done),
        .dma_rd    (dma_rd),
        .dma_wr    (dma_wr),
        .dma_a     (dma_a),
        .dma_din   (dma_din),
        .dma_dout  (dma_dout)
    );

endmodule
